// File: rtl/class_decision_unit.sv
// Top-1 class decision: captures one softmax frame, scans it serially and queues results in a FWFT FIFO.
// Optional CLASS_DECISION_TOP2_EN adds second-best tracking and the top-1/top-2 margin output.
module class_decision_unit #(
  parameter int                N_CLASSES   = 10,
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] CONF_THRESH = 16'h4000,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CLASSES*DATA_W-1:0]   probs_in,
  input  logic                          in_valid,
  output logic [3:0]                    class_out,
  output logic [DATA_W-1:0]             conf_out,
  output logic [DATA_W-1:0]             margin_out,
  output logic                          low_conf,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [7:0]                    drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SCAN, PUSH} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          idx_reg, idx_next;
  logic [DATA_W-1:0]   best_reg, best_next;
  logic [3:0]          best_idx_reg, best_idx_next;
  logic [DATA_W-1:0]   cur_p;
  logic                capture;
  logic                in_valid_d_reg;
  logic [7:0]          drop_reg, drop_next;
  logic [DATA_W-1:0]   probs_reg [N_CLASSES];

`ifdef CLASS_DECISION_TOP2_EN
  logic [DATA_W-1:0]   second_reg, second_next;
  logic [DATA_W-1:0]   fifo_margin [FIFO_DEPTH];
`endif

  logic [3:0]          fifo_class [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_conf  [FIFO_DEPTH];
  logic                fifo_low   [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;

  logic frame_start, fifo_full, pop, push_req, push_ok;
  logic drop_in, drop_push;
  logic [8:0] drop_sum;

  assign frame_start = in_valid && !in_valid_d_reg;
  assign fifo_full   = (count_reg == CNT_W'(FIFO_DEPTH));
  assign out_valid   = (count_reg != '0);
  assign pop         = out_valid && out_ready;
  assign push_req    = (state_reg == PUSH);
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign push_ok     = push_req && (!fifo_full || pop);
  assign drop_in     = frame_start && (state_reg != IDLE);
  assign drop_push   = push_req && !push_ok;
  assign drop_sum    = {1'b0, drop_reg} + 9'(drop_in) + 9'(drop_push);
  assign drop_next   = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    capture       = 1'b0;
    cur_p         = probs_reg[idx_reg];
`ifdef CLASS_DECISION_TOP2_EN
    second_next   = second_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          capture       = 1'b1;
          idx_next      = '0;
          best_next     = '0;
          best_idx_next = '0;
`ifdef CLASS_DECISION_TOP2_EN
          second_next   = '0;
`endif
          state_next    = SCAN;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (cur_p > best_reg) begin
          best_next     = cur_p;
          best_idx_next = idx_reg;
`ifdef CLASS_DECISION_TOP2_EN
          second_next   = best_reg;
        end else if (cur_p > second_reg) begin
          second_next   = cur_p;
`endif
        end
        if (idx_reg == 4'(N_CLASSES - 1)) state_next = PUSH;
        else                              idx_next   = idx_reg + 4'd1;
      end
      PUSH:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      best_reg       <= '0;
      best_idx_reg   <= '0;
      in_valid_d_reg <= 1'b0;
      drop_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
`ifdef CLASS_DECISION_TOP2_EN
      second_reg     <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      best_reg       <= best_next;
      best_idx_reg   <= best_idx_next;
      in_valid_d_reg <= in_valid;
      drop_reg       <= drop_next;
`ifdef CLASS_DECISION_TOP2_EN
      second_reg     <= second_next;
`endif
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
    end
  end

  // Frame copy and FIFO storage carry no reset; validity lives in state and count.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N_CLASSES; i++) probs_reg[i] <= probs_in[i*DATA_W +: DATA_W];
    end
    if (push_ok) begin
      fifo_class[wr_ptr_reg]  <= best_idx_reg;
      fifo_conf[wr_ptr_reg]   <= best_reg;
      fifo_low[wr_ptr_reg]    <= (best_reg < CONF_THRESH);
`ifdef CLASS_DECISION_TOP2_EN
      fifo_margin[wr_ptr_reg] <= best_reg - second_reg;
`endif
    end
  end

  assign class_out  = out_valid ? fifo_class[rd_ptr_reg] : '0;
  assign conf_out   = out_valid ? fifo_conf[rd_ptr_reg]  : '0;
  assign low_conf   = out_valid ? fifo_low[rd_ptr_reg]   : 1'b0;
`ifdef CLASS_DECISION_TOP2_EN
  assign margin_out = out_valid ? fifo_margin[rd_ptr_reg] : '0;
`else
  assign margin_out = '0;
`endif
  assign busy       = (state_reg != IDLE);
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_class_decision_unit.sv
// Randomized and directed bench for class_decision_unit against a frame-level queue model.
module tb_class_decision_unit;

  localparam int N     = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst, in_valid, out_ready;
  logic [N*DW-1:0] probs_in;
  logic [3:0]      class_out;
  logic [DW-1:0]   conf_out, margin_out;
  logic            low_conf, out_valid, busy;
  logic [7:0]      drop_count;

  class_decision_unit dut (
    .clk(clk), .rst(rst), .probs_in(probs_in), .in_valid(in_valid),
    .class_out(class_out), .conf_out(conf_out), .margin_out(margin_out),
    .low_conf(low_conf), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cls; int conf; int margin; int low; } res_t;

  int   checks = 0;
  int   failures = 0;
  res_t q[$];
  int   m_pend, m_cnt, m_prev_iv, m_drop;
  res_t m_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Top-1 is the first maximum; top-2 is the largest of the remaining elements.
  function automatic res_t eval_frame(input logic [N*DW-1:0] p);
    res_t r;
    int bi = 0, sec = 0;
    for (int i = 1; i < N; i++) if (p[i*DW +: DW] > p[bi*DW +: DW]) bi = i;
    for (int i = 0; i < N; i++) if (i != bi && int'(p[i*DW +: DW]) > sec) sec = int'(p[i*DW +: DW]);
    r.cls  = bi;
    r.conf = int'(p[bi*DW +: DW]);
`ifdef CLASS_DECISION_TOP2_EN
    r.margin = r.conf - sec;
`else
    r.margin = 0;
`endif
    r.low = (r.conf < 'h4000) ? 1 : 0;
    return r;
  endfunction

  task automatic model_step();
    int drops, pre_size, do_pop, busy_pre, fs;
    if (rst) begin
      q.delete(); m_pend = 0; m_cnt = 0; m_prev_iv = 0; m_drop = 0;
      return;
    end
    drops    = 0;
    pre_size = q.size();
    do_pop   = (pre_size > 0 && out_ready) ? 1 : 0;
    busy_pre = m_pend;
    fs       = (in_valid && !m_prev_iv) ? 1 : 0;
    m_prev_iv = in_valid;
    if (fs && busy_pre) drops++;
    if (do_pop) begin
      $display("pop class=%0d conf=%04h margin=%04h low=%0d", q[0].cls, q[0].conf, q[0].margin, q[0].low);
      void'(q.pop_front());
    end
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_pend = 0;
        if (pre_size < DEPTH || do_pop) q.push_back(m_res);
        else drops++;
      end
    end
    if (fs && !busy_pre) begin
      m_res  = eval_frame(probs_in);
      m_pend = 1;
      m_cnt  = N + 1;
    end
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, q.size() > 0);
    check("busy", busy, m_pend);
    check("drop_count", drop_count, m_drop);
    if (q.size() > 0) begin
      check("class_out", class_out, q[0].cls);
      check("conf_out", conf_out, q[0].conf);
      check("margin_out", margin_out, q[0].margin);
      check("low_conf", low_conf, q[0].low);
    end else begin
      check("class_idle", class_out, 0);
      check("conf_idle", conf_out, 0);
      check("margin_idle", margin_out, 0);
      check("low_idle", low_conf, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_frame(input int hot_a, input int hot_b, input logic [DW-1:0] hot_v,
                           input logic [DW-1:0] rest_v);
    for (int i = 0; i < N; i++) probs_in[i*DW +: DW] = (i == hot_a || i == hot_b) ? hot_v : rest_v;
  endtask

  // Counts ticks from capture until out_valid; bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  int lat, seen, expm;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; probs_in = '0;
    m_pend = 0; m_cnt = 0; m_prev_iv = 0; m_drop = 0;
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    rst = 1'b0;
    tick();

    // One-hot frame
    out_ready = 1'b1;
    set_frame(7, 7, 16'h7FFF, 16'h0001);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_result(lat);
`ifdef CLASS_DECISION_TOP2_EN
    expm = 'h7FFE;
`else
    expm = 0;
`endif
    check("onehot_latency", lat, 11);
    check("onehot_class", class_out, 7);
    check("onehot_conf", conf_out, 'h7FFF);
    check("onehot_margin", margin_out, expm);
    check("onehot_low", low_conf, 0);
    tick();
    check("onehot_one_cycle", out_valid, 0);

    // Tie frame
    set_frame(2, 5, 16'h3000, 16'h0100);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    wait_result(lat);
    check("tie_latency", lat, 11);
    check("tie_class", class_out, 2);
    check("tie_conf", conf_out, 'h3000);
    check("tie_margin", margin_out, 0);
    check("tie_low", low_conf, 1);
    repeat (2) tick();

    // FIFO overflow: five frames, consumer stalled
    out_ready = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      set_frame(w, w, 16'h6000, 16'h0010);
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      repeat (12) tick();
    end
    check("ovf_drop", drop_count, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("ovf_order", class_out, k);
      tick();
    end
    check("ovf_empty", out_valid, 0);

    // Level-held in_valid yields a single frame
    set_frame(3, 3, 16'h5000, 16'h0200);
    seen = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) seen++;
    end
    in_valid = 1'b0;
    tick();
    check("hold_results", seen, 1);
    check("hold_drop", drop_count, 1);

    // Reset during SCAN with two results queued
    out_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      set_frame(w + 8, w + 8, 16'h4800, 16'h0000);
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      repeat (12) tick();
    end
    check("rq_queued", out_valid, 1);
    set_frame(4, 4, 16'h7000, 16'h0001);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("rq_valid", out_valid, 0);
    check("rq_class", class_out, 0);
    check("rq_busy", busy, 0);
    check("rq_drop", drop_count, 0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("rq_no_result", seen, 0);

    // in_valid held across reset release captures on the first edge after reset
    out_ready = 1'b1;
    set_frame(6, 6, 16'h2000, 16'h0003);
    rst = 1'b1; in_valid = 1'b1; tick(); rst = 1'b0;
    tick(); in_valid = 1'b0;
    wait_result(lat);
    check("post_rst_latency", lat, 11);
    check("post_rst_class", class_out, 6);
    check("post_rst_low", low_conf, 1);
    repeat (2) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 799) == 0);
      if (!in_valid) begin
        for (int i = 0; i < N; i++)
          probs_in[i*DW +: DW] = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 3))
                                                              : DW'($urandom_range(0, 16'hFFFF));
        in_valid = ($urandom_range(0, 4) == 0);
      end else begin
        in_valid = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
